// File: rtl/mac_pkg.sv
// Shared types and constants for the MAC writeback register file.
package mac_pkg;
  localparam int unsigned NREGS  = 32;
  localparam int unsigned DW     = 32;
  localparam int unsigned NLANES = 4;
  localparam int unsigned IDXW   = $clog2(NREGS);

  typedef logic [IDXW-1:0]   reg_idx_t;
  typedef logic [DW-1:0]     fp_word_t;
  typedef logic [NLANES-1:0] lane_mask_t;
  typedef logic [NREGS-1:0]  reg_mask_t;

  // NREGS is a power of 2, so the IDXW-bit add wraps mod NREGS.
  function automatic reg_idx_t lane_reg(input reg_idx_t base, input int k);
    return base + reg_idx_t'(k);
  endfunction
endpackage

// File: rtl/mac_result_regfile_if.sv
// Bundle between the MAC/controller/host side and the writeback register file.
interface mac_result_regfile_if;
  import mac_pkg::*;

  logic       mac_reg_wen;
  lane_mask_t mac_word_sel;
  reg_idx_t   mac_index;
  fp_word_t   mac_result_0;
  fp_word_t   mac_result_1;
  fp_word_t   mac_result_2;
  fp_word_t   mac_result_3;
  lane_mask_t mac_nan;
  logic       iss_en;
  lane_mask_t iss_word_sel;
  reg_idx_t   iss_index;
  logic       host_wen;
  reg_idx_t   host_addr;
  fp_word_t   host_wdata;
  reg_idx_t   rd_index;
  fp_word_t   rd_data_0;
  fp_word_t   rd_data_1;
  fp_word_t   rd_data_2;
  fp_word_t   rd_data_3;
  logic       rd_busy;
  reg_mask_t  busy;
  logic       nan_flag;
  reg_idx_t   nan_reg;
  logic       nan_clr;

  modport master (
    output mac_reg_wen, mac_word_sel, mac_index,
    output mac_result_0, mac_result_1, mac_result_2, mac_result_3, mac_nan,
    output iss_en, iss_word_sel, iss_index,
    output host_wen, host_addr, host_wdata, rd_index, nan_clr,
    input  rd_data_0, rd_data_1, rd_data_2, rd_data_3, rd_busy, busy,
    input  nan_flag, nan_reg
  );

  modport slave (
    input  mac_reg_wen, mac_word_sel, mac_index,
    input  mac_result_0, mac_result_1, mac_result_2, mac_result_3, mac_nan,
    input  iss_en, iss_word_sel, iss_index,
    input  host_wen, host_addr, host_wdata, rd_index, nan_clr,
    output rd_data_0, rd_data_1, rd_data_2, rd_data_3, rd_busy, busy,
    output nan_flag, nan_reg
  );
endinterface

// File: rtl/mac_scoreboard.sv
// Per-register pending-write scoreboard; issue sets, MAC writeback clears, set wins.
// With MAC_RF_BYPASS_EN, rd_busy ignores registers being cleared this cycle.
module mac_scoreboard
  import mac_pkg::*;
(
  input  logic      CLK,
  input  logic      RST,
  input  reg_mask_t set_mask,
  input  reg_mask_t clr_mask,
  input  reg_idx_t  rd_index,
  output reg_mask_t busy,
  output logic      rd_busy
);

  reg_mask_t visible;

  always_ff @(posedge CLK) begin
    if (RST) busy <= '0;
    else     busy <= (busy & ~clr_mask) | set_mask;
  end

  always_comb begin
    visible = busy;
`ifdef MAC_RF_BYPASS_EN
    visible = busy & ~clr_mask;
`endif
    rd_busy = 1'b0;
    for (int k = 0; k < NLANES; k++) begin
      rd_busy = rd_busy | visible[lane_reg(rd_index, k)];
    end
  end

endmodule

// File: rtl/mac_result_regfile.sv
// Writeback register file for the 4-lane MAC: storage, write muxing, 4-wide read, sticky NaN.
// Optional macro MAC_RF_BYPASS_EN forwards same-cycle write data onto the read port.
module mac_result_regfile
  import mac_pkg::*;
(
  input logic                 CLK,
  input logic                 RST,
  mac_result_regfile_if.slave bus
);

  fp_word_t   regs    [NREGS];
  fp_word_t   wr_data [NREGS];
  reg_mask_t  wr_en;
  reg_mask_t  set_mask;
  reg_mask_t  clr_mask;
  reg_mask_t  busy_vec;
  logic       rd_busy_c;
  lane_mask_t lane_wen;
  fp_word_t   mac_res [NLANES];
  fp_word_t   rd_val  [NLANES];
  logic       nan_hit;
  reg_idx_t   nan_hit_reg;
  logic       nan_flag_q;
  reg_idx_t   nan_reg_q;

  assign mac_res[0] = bus.mac_result_0;
  assign mac_res[1] = bus.mac_result_1;
  assign mac_res[2] = bus.mac_result_2;
  assign mac_res[3] = bus.mac_result_3;
  assign lane_wen   = bus.mac_word_sel & {NLANES{bus.mac_reg_wen}};

  // Per-register issue/writeback masks after address wrap.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    for (int k = 0; k < NLANES; k++) begin
      if (bus.iss_en && bus.iss_word_sel[k]) set_mask[lane_reg(bus.iss_index, k)] = 1'b1;
      if (lane_wen[k]) clr_mask[lane_reg(bus.mac_index, k)] = 1'b1;
    end
  end

  // Host write first so a same-register MAC lane overrides it.
  always_comb begin
    wr_en = '0;
    for (int r = 0; r < NREGS; r++) wr_data[r] = bus.host_wdata;
    wr_en[bus.host_addr] = bus.host_wen;
    for (int k = 0; k < NLANES; k++) begin
      if (lane_wen[k]) begin
        wr_en[lane_reg(bus.mac_index, k)]   = 1'b1;
        wr_data[lane_reg(bus.mac_index, k)] = mac_res[k];
      end
    end
  end

  always_ff @(posedge CLK) begin
    for (int r = 0; r < NREGS; r++) begin
      if (RST)           regs[r] <= '0;
      else if (wr_en[r]) regs[r] <= wr_data[r];
    end
  end

  // Lowest enabled lane reporting NaN.
  always_comb begin
    nan_hit     = 1'b0;
    nan_hit_reg = '0;
    for (int k = 0; k < NLANES; k++) begin
      if (lane_wen[k] && bus.mac_nan[k] && !nan_hit) begin
        nan_hit     = 1'b1;
        nan_hit_reg = lane_reg(bus.mac_index, k);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      nan_flag_q <= 1'b0;
      nan_reg_q  <= '0;
    end else if (bus.nan_clr) begin
      nan_flag_q <= nan_hit;
      nan_reg_q  <= nan_hit ? nan_hit_reg : reg_idx_t'(0);
    end else if (!nan_flag_q && nan_hit) begin
      nan_flag_q <= 1'b1;
      nan_reg_q  <= nan_hit_reg;
    end
  end

  always_comb begin
    for (int k = 0; k < NLANES; k++) begin
      rd_val[k] = regs[lane_reg(bus.rd_index, k)];
`ifdef MAC_RF_BYPASS_EN
      if (wr_en[lane_reg(bus.rd_index, k)]) rd_val[k] = wr_data[lane_reg(bus.rd_index, k)];
`endif
    end
  end

  mac_scoreboard u_scoreboard (
    .CLK      (CLK),
    .RST      (RST),
    .set_mask (set_mask),
    .clr_mask (clr_mask),
    .rd_index (bus.rd_index),
    .busy     (busy_vec),
    .rd_busy  (rd_busy_c)
  );

  assign bus.rd_data_0 = rd_val[0];
  assign bus.rd_data_1 = rd_val[1];
  assign bus.rd_data_2 = rd_val[2];
  assign bus.rd_data_3 = rd_val[3];
  assign bus.rd_busy   = rd_busy_c;
  assign bus.busy      = busy_vec;
  assign bus.nan_flag  = nan_flag_q;
  assign bus.nan_reg   = nan_reg_q;

endmodule
